// File: rtl/truth_table_scanner_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the truth_table_scanner block.
//   scan_state_t : FSM state encoding (IDLE, APPLY, SETTLE, FINISH)
//   N_DEF        : default number of inputs of the function under test
//   mask_width() : minterm-mask width for n inputs (2^n)
// Optional build macro: SCAN_SETTLE_EN (see truth_table_scanner.sv).
// ---------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2,
        FINISH = 2'd3
    } scan_state_t;

    localparam int N_DEF = 3;

    function automatic int mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_if
// Groups the scan control, the function-under-test path and the result bus.
//   start, expected   : scan request and reference minterm mask
//   fx_in             : 1-bit output of the function under test
//   vec_out           : input vector driven to the function under test
//   busy, done        : scan in progress / one-cycle completion pulse
//   mask, match,
//   mism_cnt,
//   first_fail        : captured minterm mask and its comparison results
// Modports:
//   master : the harness side (drives start/expected/fx_in)
//   slave  : the scanner side
// Optional build macro: SCAN_SETTLE_EN (affects only the scanner timing).
// ---------------------------------------------------------------------------
interface truth_table_scanner_if
    import scan_pkg::*;
#(
    parameter int N = N_DEF
);
    localparam int W = mask_width(N);

    logic             start;
    logic [W-1:0]     expected;
    logic             fx_in;
    logic [N-1:0]     vec_out;
    logic             busy;
    logic             done;
    logic [W-1:0]     mask;
    logic             match;
    logic [N:0]       mism_cnt;
    logic [N-1:0]     first_fail;

    modport master (
        output start, expected, fx_in,
        input  vec_out, busy, done, mask, match, mism_cnt, first_fail
    );

    modport slave (
        input  start, expected, fx_in,
        output vec_out, busy, done, mask, match, mism_cnt, first_fail
    );

endinterface

// File: rtl/truth_table_scanner_cmp.sv
// ---------------------------------------------------------------------------
// scan_cmp
// Purely combinational comparison of the captured minterm mask against the
// reference mask.
//   mask       (in)  : captured minterm mask, W = 2^N bits
//   expected_q (in)  : reference mask captured at scan start
//   match      (out) : 1 when both masks are identical
//   mism_cnt   (out) : number of differing bits, 0..W
//   first_fail (out) : lowest differing index, 0 when match = 1
// Optional build macro: SCAN_SETTLE_EN (no effect on this module).
// ---------------------------------------------------------------------------
module scan_cmp
    import scan_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [mask_width(N)-1:0] mask,
    input  logic [mask_width(N)-1:0] expected_q,
    output logic                     match,
    output logic [N:0]               mism_cnt,
    output logic [N-1:0]             first_fail
);
    localparam int W = mask_width(N);

    logic [W-1:0] diff;

    assign diff  = mask ^ expected_q;
    assign match = (diff == '0);

    // Popcount and lowest-index priority encode in one pass; walking from the
    // top index down lets the last hit be the lowest one.
    always_comb begin
        mism_cnt   = '0;
        first_fail = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                mism_cnt   = mism_cnt + (N + 1)'(1);
                first_fail = N'(i);
            end
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Sweeps all 2^N input vectors into a combinational function under test,
// records f(k) into bit k of a minterm mask, and compares the result with a
// reference mask captured at start.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (aborts a scan, no done)
//   bus  : truth_table_scanner_if.slave
//          start/expected in, fx_in in, vec_out/busy/done out,
//          mask/match/mism_cnt/first_fail out
// Build macro SCAN_SETTLE_EN:
//   defined     : each vector is held two cycles (APPLY then SETTLE) and
//                 sampled at the end of the second, tolerating one register
//                 stage in the function path; done 2W edges after start.
//   not defined : one cycle per vector, done W edges after start.
// ---------------------------------------------------------------------------
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus
);
    localparam int W = mask_width(N);
    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE  = N'(1);

    scan_state_t  state_q, state_d;
    logic [N-1:0] vec_q, vec_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] expected_q, expected_d;

    logic         cmp_match;
    logic [N:0]   cmp_mism_cnt;
    logic [N-1:0] cmp_first_fail;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        mask_d     = mask_q;
        expected_d = expected_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    expected_d = bus.expected;
                    mask_d     = '0;
                    vec_d      = '0;
                    state_d    = APPLY;
                end
            end

            APPLY: begin
`ifdef SCAN_SETTLE_EN
                // First cycle of the vector: let a registered function catch up.
                state_d = SETTLE;
`else
                mask_d[vec_q] = bus.fx_in;
                if (vec_q == VEC_LAST) begin
                    state_d = FINISH;
                end else begin
                    vec_d = vec_q + VEC_ONE;
                end
`endif
            end

`ifdef SCAN_SETTLE_EN
            SETTLE: begin
                mask_d[vec_q] = bus.fx_in;
                if (vec_q == VEC_LAST) begin
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + VEC_ONE;
                    state_d = APPLY;
                end
            end
`endif

            FINISH: begin
                // start is deliberately not looked at here: no queueing.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            mask_q     <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            mask_q     <= mask_d;
            expected_q <= expected_d;
        end
    end

    scan_cmp #(
        .N (N)
    ) u_cmp (
        .mask       (mask_q),
        .expected_q (expected_q),
        .match      (cmp_match),
        .mism_cnt   (cmp_mism_cnt),
        .first_fail (cmp_first_fail)
    );

    assign bus.vec_out    = vec_q;
    assign bus.busy       = (state_q == APPLY) || (state_q == SETTLE);
    assign bus.done       = (state_q == FINISH);
    assign bus.mask       = mask_q;
    assign bus.match      = cmp_match;
    assign bus.mism_cnt   = cmp_mism_cnt;
    assign bus.first_fail = cmp_first_fail;

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
// Directed bench for truth_table_scanner (N = 3). The function under test is
// selected by fx_mode: constant 0, constant 1, SoP(2,5,6,7) of vec_out, or
// the same SoP delayed by one register. Honours SCAN_SETTLE_EN.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;

`ifdef SCAN_SETTLE_EN
    localparam int         LAT      = 16;
    localparam logic [7:0] DLY_MASK = 8'hE4;
`else
    localparam int         LAT      = 8;
    localparam logic [7:0] DLY_MASK = 8'hC8;
`endif

    localparam logic [1:0] FX_ZERO = 2'd0;
    localparam logic [1:0] FX_ONE  = 2'd1;
    localparam logic [1:0] FX_SOP  = 2'd2;
    localparam logic [1:0] FX_DLY  = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] fx_mode;
    logic       fx_dly;
    int         cyc;
    int         done_cnt;
    int         n_chk;
    int         n_fail;

    truth_table_scanner_if #(.N(3)) bus ();

    truth_table_scanner #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc      = 0;
        done_cnt = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    // SoP(2,5,6,7): minterm table 8'hE4
    function automatic logic sop(input logic [2:0] v);
        logic [7:0] t;
        t = 8'hE4;
        return t[v];
    endfunction

    always @(posedge clk) begin
        if (rst) fx_dly <= 1'b0;
        else     fx_dly <= sop(bus.vec_out);
    end

    always_comb begin
        bus.fx_in = 1'b0;
        case (fx_mode)
            FX_ZERO: bus.fx_in = 1'b0;
            FX_ONE:  bus.fx_in = 1'b1;
            FX_SOP:  bus.fx_in = sop(bus.vec_out);
            default: bus.fx_in = fx_dly;
        endcase
    end

    // Launches one scan and returns at the falling edge inside the done cycle.
    // lat is the number of edges from acceptance to done (-1 on timeout).
    task automatic run_scan(input logic [7:0] exp, output int lat,
                            output logic busy0, output logic [2:0] vec0);
        int t0;
        lat   = -1;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.expected = exp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t0 = cyc;
        @(negedge clk);
        busy0 = bus.busy;
        vec0  = bus.vec_out;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", bus.mask); end
        n_chk++; if (bus.vec_out !== 3'd0) begin n_fail++; $display("FAIL reset_vec: got %0d want 0", bus.vec_out); end
        n_chk++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL reset_match: got %b want 1", bus.match); end
        n_chk++; if (bus.mism_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_mism: got %0d want 0", bus.mism_cnt); end
        n_chk++; if (bus.first_fail !== 3'd0) begin n_fail++; $display("FAIL reset_ff: got %0d want 0", bus.first_fail); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_sop_match();
        int lat; logic b0; logic [2:0] v0;
        fx_mode = FX_SOP;
        run_scan(8'hE4, lat, b0, v0);
        n_chk++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", b0); end
        n_chk++; if (v0 !== 3'd0) begin n_fail++; $display("FAIL start_vec: got %0d want 0", v0); end
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL sop_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sop_busy_in_done: got %b want 0", bus.busy); end
        n_chk++; if (bus.mask !== 8'hE4) begin n_fail++; $display("FAIL sop_mask: got %h want e4", bus.mask); end
        n_chk++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL sop_match: got %b want 1", bus.match); end
        n_chk++; if (bus.mism_cnt !== 4'd0) begin n_fail++; $display("FAIL sop_mism: got %0d want 0", bus.mism_cnt); end
        @(negedge clk);
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
        n_chk++; if (bus.vec_out !== 3'd7) begin n_fail++; $display("FAIL vec_hold: got %0d want 7", bus.vec_out); end
        n_chk++; if (bus.mask !== 8'hE4) begin n_fail++; $display("FAIL mask_hold: got %h want e4", bus.mask); end
    endtask

    task automatic test_sop_mismatch();
        int lat; logic b0; logic [2:0] v0;
        fx_mode = FX_SOP;
        run_scan(8'hE5, lat, b0, v0);
        n_chk++; if (bus.mask !== 8'hE4) begin n_fail++; $display("FAIL mm_mask: got %h want e4", bus.mask); end
        n_chk++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL mm_match: got %b want 0", bus.match); end
        n_chk++; if (bus.mism_cnt !== 4'd1) begin n_fail++; $display("FAIL mm_cnt: got %0d want 1", bus.mism_cnt); end
        n_chk++; if (bus.first_fail !== 3'd0) begin n_fail++; $display("FAIL mm_ff: got %0d want 0", bus.first_fail); end
        run_scan(8'h60, lat, b0, v0);
        // E4 ^ 60 = 84 : bits 2 and 7 differ
        n_chk++; if (bus.mism_cnt !== 4'd2) begin n_fail++; $display("FAIL mm2_cnt: got %0d want 2", bus.mism_cnt); end
        n_chk++; if (bus.first_fail !== 3'd2) begin n_fail++; $display("FAIL mm2_ff: got %0d want 2", bus.first_fail); end
    endtask

    task automatic test_const();
        int lat; logic b0; logic [2:0] v0;
        fx_mode = FX_ZERO;
        run_scan(8'hFF, lat, b0, v0);
        n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL zero_mask: got %h want 00", bus.mask); end
        n_chk++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL zero_match: got %b want 0", bus.match); end
        n_chk++; if (bus.mism_cnt !== 4'd8) begin n_fail++; $display("FAIL zero_cnt: got %0d want 8", bus.mism_cnt); end
        n_chk++; if (bus.first_fail !== 3'd0) begin n_fail++; $display("FAIL zero_ff: got %0d want 0", bus.first_fail); end
        // back-to-back: next scan launched right after the done cycle
        fx_mode = FX_ONE;
        run_scan(8'hFF, lat, b0, v0);
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (bus.mask !== 8'hFF) begin n_fail++; $display("FAIL one_mask: got %h want ff", bus.mask); end
        n_chk++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL one_match: got %b want 1", bus.match); end
        n_chk++; if (bus.mism_cnt !== 4'd0) begin n_fail++; $display("FAIL one_cnt: got %0d want 0", bus.mism_cnt); end
    endtask

    task automatic test_restart_ignored();
        int t0; int lat; int d0;
        fx_mode = FX_SOP;
        @(posedge clk); #1;
        d0 = done_cnt;
        bus.start = 1'b1; bus.expected = 8'hE4;
        @(posedge clk); #1;
        bus.start = 1'b0; t0 = cyc;
        repeat (3) @(posedge clk); #1;
        bus.start = 1'b1; bus.expected = 8'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = cyc - t0; break; end
        end
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (bus.mask !== 8'hE4) begin n_fail++; $display("FAIL restart_mask: got %h want e4", bus.mask); end
        n_chk++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL restart_match: got %b want 1", bus.match); end
        repeat (30) @(posedge clk);
        #1;
        n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL restart_no_queue: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int d0; int lat; logic b0; logic [2:0] v0;
        fx_mode = FX_SOP;
        @(posedge clk); #1;
        d0 = done_cnt;
        bus.start = 1'b1; bus.expected = 8'h0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL abort_mask: got %h want 00", bus.mask); end
        n_chk++; if (bus.vec_out !== 3'd0) begin n_fail++; $display("FAIL abort_vec: got %0d want 0", bus.vec_out); end
        n_chk++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL abort_match: got %b want 1", bus.match); end
        repeat (20) @(posedge clk);
        #1;
        n_chk++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        run_scan(8'hE4, lat, b0, v0);
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL after_abort_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (bus.mask !== 8'hE4) begin n_fail++; $display("FAIL after_abort_mask: got %h want e4", bus.mask); end
    endtask

    task automatic test_delayed_fn();
        int lat; logic b0; logic [2:0] v0;
        // reset first so vec_out and the delay register both start at 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fx_mode = FX_DLY;
        run_scan(8'hE4, lat, b0, v0);
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL dly_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (bus.mask !== DLY_MASK) begin n_fail++; $display("FAIL dly_mask: got %h want %h", bus.mask, DLY_MASK); end
        n_chk++; if (bus.match !== (DLY_MASK == 8'hE4)) begin n_fail++; $display("FAIL dly_match: got %b want %b", bus.match, (DLY_MASK == 8'hE4)); end
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.expected = 8'h00;
        fx_mode      = FX_ZERO;
        test_reset();
        test_sop_match();
        test_sop_mismatch();
        test_const();
        test_restart_ignored();
        test_reset_mid();
        test_delayed_fn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
        $fatal(1);
    end

endmodule
